// File: rtl/axi_slave_ram.sv
// rtl/axi_slave_ram.sv - AXI3 responder over a word-addressed RAM, independent read and write FSMs
module axi_slave_ram #(
    parameter int ADDR_W = 14
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // WRAP window minus one is (len+1)*4-1 == {len, 2'b11}
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                              input logic [1:0] burst);
        logic [31:0] mask;
        mask = {26'd0, len, 2'b11};
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   if (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)
                         next_addr = (a & ~mask) | ((a + 32'd4) & mask);
                     else
                         next_addr = a + 32'd4;
            default: next_addr = a + 32'd4;
        endcase
    endfunction

    r_state_t    r_state;
    logic [31:0] r_addr;
    logic [31:0] r_next;
    logic [3:0]  r_len;
    logic [1:0]  r_burst;
    logic [3:0]  r_cnt;

    assign r_next = next_addr(r_addr, r_len, r_burst);
    assign rresp  = 2'b00;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= 4'd0;
            rdata   <= 32'd0;
            r_addr  <= 32'd0;
            r_len   <= 4'd0;
            r_burst <= 2'b00;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                R_IDLE: if (arvalid) begin
                    r_addr  <= araddr;
                    r_len   <= arlen;
                    r_burst <= arburst;
                    r_cnt   <= 4'd0;
                    rid     <= arid;
                    rdata   <= mem[araddr[ADDR_W+1:2]];
                    rlast   <= (arlen == 4'd0);
                    rvalid  <= 1'b1;
                    arready <= 1'b0;
                    r_state <= R_DATA;
                end
                R_DATA: if (rready) begin
                    if (r_cnt == r_len) begin
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_addr <= r_next;
                        rdata  <= mem[r_next[ADDR_W+1:2]];
                        rlast  <= (r_cnt + 4'd1 == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [3:0]  w_len;
    logic [1:0]  w_burst;
    logic [3:0]  w_id;
    logic [4:0]  w_cnt;
    logic        w_err;
    logic        beat_ok;

    // Counter saturates at 16 so an overlong burst cannot wrap back into range
    assign beat_ok = (w_state == W_DATA) && wvalid && (wid == w_id) && (w_cnt <= {1'b0, w_len});

    always_ff @(posedge aclk) begin
        if (beat_ok) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[w_addr[ADDR_W+1:2]][b*8 +: 8] <= wdata[b*8 +: 8];
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= 4'd0;
            bresp   <= 2'b00;
            w_addr  <= 32'd0;
            w_len   <= 4'd0;
            w_burst <= 2'b00;
            w_id    <= 4'd0;
            w_cnt   <= 5'd0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (awvalid) begin
                    w_addr  <= awaddr;
                    w_len   <= awlen;
                    w_burst <= awburst;
                    w_id    <= awid;
                    w_cnt   <= 5'd0;
                    w_err   <= 1'b0;
                    awready <= 1'b0;
                    wready  <= 1'b1;
                    w_state <= W_DATA;
                end
                W_DATA: if (wvalid) begin
                    if (beat_ok) w_addr <= next_addr(w_addr, w_len, w_burst);
                    if (w_cnt != 5'd16) w_cnt <= w_cnt + 5'd1;
                    if (wlast) begin
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bid     <= w_id;
                        bresp   <= (w_err || !beat_ok || w_cnt != {1'b0, w_len}) ? 2'b10 : 2'b00;
                        w_state <= W_RESP;
                    end else if (!beat_ok) begin
                        w_err <= 1'b1;
                    end
                end
                W_RESP: if (bready) begin
                    bvalid  <= 1'b0;
                    awready <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_ram.sv
// tb/tb_axi_slave_ram.sv - self-checking bench for axi_slave_ram with a word-level memory model
module tb_axi_slave_ram;
    logic aclk, areset;
    logic [3:0] arid, rid, awid, wid, bid, awlen, arlen, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [1:0] arburst, rresp, awburst, bresp;
    logic arvalid, arready, rlast, rvalid, rready;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_slave_ram #(.ADDR_W(14)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic [31:0] mdl [int];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [3:0]  wids [16];
    logic [31:0] rd [16];
    logic        rl [16];
    logic [3:0]  rids [16];

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                              input logic [1:0] burst, input int i);
        logic [31:0] size, base;
        if (burst == 2'b00) return a;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            size = 32'((len + 1) * 4);
            base = a - (a % size);
            return base + ((a - base + 32'(4 * i)) % size);
        end
        return a + 32'(4 * i);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FFF);
    endfunction

    task automatic mdl_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int nb, output logic [1:0] resp);
        int k = 0;
        bit err = 0;
        logic [31:0] w;
        for (int i = 0; i < nb; i++) begin
            if (wids[i] == id && i <= len) begin
                w = mdl.exists(widx(beat_addr(addr, len, burst, k))) ? mdl[widx(beat_addr(addr, len, burst, k))] : 32'h0;
                for (int b = 0; b < 4; b++) if (ws[i][b]) w[b*8 +: 8] = wd[i][b*8 +: 8];
                mdl[widx(beat_addr(addr, len, burst, k))] = w;
                k++;
            end else err = 1;
        end
        if (nb - 1 != len) err = 1;
        resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int nb,
                            output logic [1:0] resp, output logic [3:0] rbid, output int lat);
        int n;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1;
        n = 0;
        while (!awready && n < 100) begin @(negedge aclk); n++; end
        chk("aw_ready", awready, 1);
        @(negedge aclk);
        awvalid = 0;
        for (int i = 0; i < nb; i++) begin
            wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wid = wids[i]; wlast = (i == nb - 1);
            n = 0;
            while (!wready && n < 100) begin @(negedge aclk); n++; end
            chk("w_ready", wready, 1);
            @(negedge aclk);
        end
        wvalid = 0; wlast = 0;
        lat = 0;
        while (!bvalid && lat < 100) begin @(negedge aclk); lat++; end
        rbid = bid; resp = bresp;
        bready = 1;
        @(negedge aclk);
        bready = 0;
        chk("b_drop", bvalid, 0);
    endtask

    // stall_mode 0: rready held high, 1: toggles 1,0,1,0, 2: random
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int stall_mode, input int max_beats);
        int n, beat, cyc;
        bit stalled, expect_v;
        logic [31:0] pd;
        logic pl;
        logic [3:0] pid;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1;
        n = 0;
        while (!arready && n < 100) begin @(negedge aclk); n++; end
        chk("ar_ready", arready, 1);
        @(negedge aclk);
        arvalid = 0;
        chk("ar_busy", arready, 0);
        beat = 0; cyc = 0; stalled = 0; expect_v = 1;
        pd = 0; pl = 0; pid = 0;
        while (beat < max_beats && cyc < 300) begin
            case (stall_mode)
                0: rready = 1;
                1: rready = (cyc % 2 == 0);
                default: rready = ($urandom % 3 != 0);
            endcase
            if (expect_v) chk("r_valid", rvalid, 1);
            if (rvalid) begin
                if (stalled) begin
                    chk("r_hold_data", rdata, pd);
                    chk("r_hold_last", rlast, pl);
                    chk("r_hold_id", rid, pid);
                end
                chk("r_resp", rresp, 0);
                if (rready) begin
                    rd[beat] = rdata; rl[beat] = rlast; rids[beat] = rid;
                    beat++; stalled = 0; expect_v = (beat <= len);
                end else begin
                    stalled = 1; pd = rdata; pl = rlast; pid = rid; expect_v = 1;
                end
            end
            @(negedge aclk);
            cyc++;
        end
        rready = 0;
        chk("r_beats", beat, max_beats);
    endtask

    task automatic check_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst);
        for (int i = 0; i <= len; i++) begin
            chk("rd_data", rd[i], mdl[widx(beat_addr(addr, len, burst, i))]);
            chk("rd_last", rl[i], (i == len));
            chk("rd_id", rids[i], id);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [3:0][31:0] exp;
    } rvec_t;

    function automatic rvec_t mk(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                                 input logic [31:0] e0, e1, e2, e3);
        rvec_t v;
        v.addr = a; v.len = l; v.burst = b;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rvec_t tbl [6];
        logic [1:0] resp, eresp;
        logic [3:0] rb, id, len;
        logic [1:0] burst;
        logic [31:0] addr;
        int lat, nb;

        tbl[0] = mk(32'h48, 4'd3, 2'b10, 32'hC, 32'hD, 32'hA, 32'hB);
        tbl[1] = mk(32'h44, 4'd2, 2'b00, 32'hB, 32'hB, 32'hB, 32'h0);
        tbl[2] = mk(32'h4C, 4'd1, 2'b10, 32'hD, 32'hC, 32'h0, 32'h0);
        tbl[3] = mk(32'h44, 4'd2, 2'b10, 32'hB, 32'hC, 32'hD, 32'h0);
        tbl[4] = mk(32'h40, 4'd3, 2'b11, 32'hA, 32'hB, 32'hC, 32'hD);
        tbl[5] = mk(32'h4C, 4'd3, 2'b10, 32'hD, 32'hA, 32'hB, 32'hC);

        aclk = 0; areset = 1;
        arid = 0; araddr = 0; arlen = 0; arburst = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awburst = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        repeat (2) @(negedge aclk);
        chk("rst_arready", arready, 1);
        chk("rst_awready", awready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rdata", rdata, 0);
        areset = 0;
        @(negedge aclk);

        // single write then readback
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wids[0] = 4'd3;
        mdl_write(4'd3, 32'h100, 0, 2'b01, 1, eresp);
        do_write(4'd3, 32'h100, 4'd0, 2'b01, 1, resp, rb, lat);
        chk("single_bresp", resp, 2'b00);
        chk("single_bid", rb, 4'd3);
        chk("single_blat", lat, 0);
        do_read(4'd3, 32'h100, 4'd0, 2'b01, 0, 1);
        chk("single_rdata", rd[0], 32'hDEADBEEF);
        chk("single_rlast", rl[0], 1);
        chk("single_rid", rids[0], 4'd3);
        chk("r_idle_arready", arready, 1);
        chk("r_idle_rvalid", rvalid, 0);

        // INCR burst with rready toggling
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; wids[i] = 4'd1; end
        mdl_write(4'd1, 32'h200, 3, 2'b01, 4, eresp);
        do_write(4'd1, 32'h200, 4'd3, 2'b01, 4, resp, rb, lat);
        chk("incr_bresp", resp, 2'b00);
        do_read(4'd1, 32'h200, 4'd3, 2'b01, 1, 4);
        for (int i = 0; i < 4; i++) begin
            chk("incr_rdata", rd[i], 32'(i + 1));
            chk("incr_rlast", rl[i], (i == 3));
        end

        // WRAP/FIXED table
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(10 + i); ws[i] = 4'hF; wids[i] = 4'd2; end
        mdl_write(4'd2, 32'h40, 3, 2'b01, 4, eresp);
        do_write(4'd2, 32'h40, 4'd3, 2'b01, 4, resp, rb, lat);
        for (int t = 0; t < 6; t++) begin
            do_read(4'd7, tbl[t].addr, tbl[t].len, tbl[t].burst, 2, int'(tbl[t].len) + 1);
            for (int i = 0; i <= int'(tbl[t].len); i++) begin
                chk($sformatf("tbl%0d_rdata%0d", t, i), rd[i], tbl[t].exp[i]);
                chk($sformatf("tbl%0d_rlast%0d", t, i), rl[i], (i == int'(tbl[t].len)));
            end
        end

        // byte strobes
        wd[0] = 32'h11223344; ws[0] = 4'hF; wids[0] = 4'd0;
        mdl_write(4'd0, 32'h300, 0, 2'b01, 1, eresp);
        do_write(4'd0, 32'h300, 4'd0, 2'b01, 1, resp, rb, lat);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        mdl_write(4'd0, 32'h300, 0, 2'b01, 1, eresp);
        do_write(4'd0, 32'h300, 4'd0, 2'b01, 1, resp, rb, lat);
        do_read(4'd0, 32'h300, 4'd0, 2'b01, 0, 1);
        chk("strb_rdata", rd[0], 32'h11BB33DD);

        // short burst: wlast on first of two beats
        wd[0] = 32'h99; ws[0] = 4'hF; wids[0] = 4'd4;
        mdl_write(4'd4, 32'h400, 1, 2'b01, 1, eresp);
        do_write(4'd4, 32'h400, 4'd1, 2'b01, 1, resp, rb, lat);
        chk("short_bresp", resp, 2'b10);
        chk("short_bid", rb, 4'd4);

        // wid mismatch drops the beat
        wd[0] = 32'h55; ws[0] = 4'hF; wids[0] = 4'd2;
        mdl_write(4'd2, 32'h600, 0, 2'b01, 1, eresp);
        do_write(4'd2, 32'h600, 4'd0, 2'b01, 1, resp, rb, lat);
        wd[0] = 32'h77; wids[0] = 4'd5;
        mdl_write(4'd2, 32'h600, 0, 2'b01, 1, eresp);
        do_write(4'd2, 32'h600, 4'd0, 2'b01, 1, resp, rb, lat);
        chk("wid_bresp", resp, 2'b10);
        do_read(4'd2, 32'h600, 4'd0, 2'b01, 0, 1);
        chk("wid_rdata", rd[0], 32'h55);

        // concurrent write and read on disjoint words
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; wids[i] = 4'd6; end
        mdl_write(4'd6, 32'h800, 15, 2'b01, 16, eresp);
        fork
            do_write(4'd6, 32'h800, 4'd15, 2'b01, 16, resp, rb, lat);
            do_read(4'd1, 32'h200, 4'd3, 2'b01, 2, 4);
        join
        chk("conc_bresp", resp, 2'b00);
        check_read(4'd1, 32'h200, 3, 2'b01);
        do_read(4'd6, 32'h800, 4'd15, 2'b01, 0, 16);
        check_read(4'd6, 32'h800, 15, 2'b01);

        // reset in the middle of a read burst
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h500 + 32'(i); ws[i] = 4'hF; wids[i] = 4'd9; end
        mdl_write(4'd9, 32'h500, 7, 2'b01, 8, eresp);
        do_write(4'd9, 32'h500, 4'd7, 2'b01, 8, resp, rb, lat);
        do_read(4'd9, 32'h500, 4'd7, 2'b01, 0, 3);
        chk("mid_rvalid", rvalid, 1);
        areset = 1;
        #1;
        chk("rst_async_rvalid", rvalid, 0);
        @(negedge aclk);
        areset = 0;
        @(negedge aclk);
        chk("post_rst_arready", arready, 1);
        do_read(4'd9, 32'h500, 4'd7, 2'b01, 2, 8);
        check_read(4'd9, 32'h500, 7, 2'b01);
        do_read(4'd3, 32'h100, 4'd0, 2'b01, 0, 1);
        chk("post_rst_keep", rd[0], 32'hDEADBEEF);

        // randomized traffic against the model
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; wids[i] = 4'd0; end
            mdl_write(4'd0, 32'h1000 + 32'(p * 64), 15, 2'b01, 16, eresp);
            do_write(4'd0, 32'h1000 + 32'(p * 64), 4'd15, 2'b01, 16, resp, rb, lat);
        end
        for (int it = 0; it < 60; it++) begin
            id = 4'($urandom);
            len = 4'($urandom);
            burst = 2'($urandom);
            addr = 32'h1000 + 32'(($urandom % 64) * 4);
            if ($urandom % 2 == 0) begin
                nb = ($urandom % 5 == 0) ? int'($urandom % 16) + 1 : int'(len) + 1;
                for (int i = 0; i < 16; i++) begin
                    wd[i] = $urandom;
                    ws[i] = 4'($urandom);
                    wids[i] = ($urandom % 8 == 0) ? (id ^ 4'(1 + $urandom % 15)) : id;
                end
                mdl_write(id, addr, int'(len), burst, nb, eresp);
                do_write(id, addr, len, burst, nb, resp, rb, lat);
                chk("rnd_bresp", resp, eresp);
                chk("rnd_bid", rb, id);
            end else begin
                do_read(id, addr, len, burst, 2, int'(len) + 1);
                check_read(id, addr, int'(len), burst);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_slave_ram.md
Name:
axi_slave_ram

Overview:
AXI3 responder (slave) fronting a word-addressed register-file RAM; it is the memory-side endpoint for the CPU's AXI master port in simulation and FPGA builds. Independent read and write channel FSMs, one outstanding transaction per direction, FIXED/INCR/WRAP bursts of 1–16 32-bit beats. Lock/cache/prot/size from the master are not consumed; all transfers are 32-bit words.

Parameters:
ADDR_W, 14, word-address width; RAM holds 2^ADDR_W words, indexed by addr[ADDR_W+1:2], upper bits ignored (aliasing).

Ports:
aclk  in  1  clock
areset  in  1  asynchronous reset, active-high
arid  in  4  read ID
araddr  in  32  read start byte address
arlen  in  4  beats-1
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 treated as INCR
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  4  read ID echo
rdata  out  32  read data
rresp  out  2  read response
rlast  out  1  last read beat
rvalid  out  1  R valid
rready  in  1  R ready
awid  in  4  write ID
awaddr  in  32  write start byte address
awlen  in  4  beats-1
awburst  in  2  burst type, same encoding as arburst
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  4  write data ID
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  4  write response ID
bresp  out  2  write response
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- Reset (async, any state): both FSMs to IDLE; arready=awready=1, rvalid=rlast=wready=bvalid=0, rid=bid=0, rresp=bresp=00, rdata=0. RAM contents are not reset. In-flight bursts are abandoned.
- Read FSM R_IDLE/R_DATA. R_IDLE: arready=1; on arvalid&arready latch id, addr, len, burst, clear beat counter, go R_DATA; arready=0 outside R_IDLE.
- R_DATA: rvalid=1 from the cycle after the AR handshake (1-cycle latency); rdata registered from RAM[addr]; rdata/rid/rlast held stable while rvalid&!rready. On rvalid&rready: if counter==len, rlast beat done -> R_IDLE (arready=1 next cycle, so back-to-back bursts have one bubble); else counter+1, next address, next beat valid the following cycle with no bubble. rlast=1 exactly on beat len. rresp always 00 (OKAY).
- Next address: FIXED keeps addr; INCR adds 4 (32-bit wrap, no 4KB check); WRAP with len in {1,3,7,15} wraps within an aligned (len+1)*4-byte window, any other len behaves as INCR.
- Write FSM W_IDLE/W_DATA/W_RESP. W_IDLE: awready=1; on handshake latch id, addr, len, burst, clear counter, set err=0, go W_DATA.
- W_DATA: wready=1. Each wvalid&wready beat: if wid==latched id and counter<=len, write bytes of wdata selected by wstrb to RAM[addr] at that clock edge, advance address; else drop beat and set err. On the beat with wlast: set err if counter!=len, go W_RESP. Beats are counted only on handshake.
- W_RESP: bvalid=1, bid=latched id, bresp=10 (SLVERR) if err else 00; held until bready; then W_IDLE.
- W data before AW: wready=0 in W_IDLE, W waits.
- Simultaneous read and write to the same word: read beat captures pre-write data; write visible to reads fetched in later cycles.
- Read and write channels fully concurrent; neither stalls the other.

Test Plan:
- Single write: AW addr 0x100 len 0 INCR id 3, W 0xDEADBEEF strb 1111 wlast -> bvalid 1 cycle after, bid 3 bresp 00; then AR 0x100 len 0 -> rdata 0xDEADBEEF, rlast=1, rid 3.
- INCR burst: write 4 beats at 0x200 data 1,2,3,4; read len 3 with rready toggling 1,0,1,0 -> rdata 1,2,3,4 in order, stable across stalls, rlast only on 4th.
- WRAP: preload 0x40..0x4C with A,B,C,D; AR 0x48 len 3 WRAP -> C,D,A,B; FIXED len 2 at 0x44 -> B,B,B.
- Byte strobes: word 0x11223344 at 0x300, write 0xAABBCCDD strb 0101 -> readback 0x11BB33DD.
- Errors: AW len 1 with wlast on first beat -> bresp 10; W beat with wid!=awid -> not written, bresp 10.
- Reset mid-read-burst of len 7 after 3 beats -> rvalid 0 asynchronously, arready 1 after release, next read returns correct data; RAM contents preserved.
